// File: rtl/traffic_light_ctrl_p.sv
// ---------------------------------------------------------------------------
// traffic_light_ctrl_p
//
// Controller for a two-road intersection with a pedestrian phase and a night
// flashing mode. All durations are counted in ticks of an external time-base
// enable rather than in clocks. Lamp outputs are decoded only from registered
// state, so no input has a combinational path to an output.
//
// Parameters
//   G1_T, G2_T : green duration of road 1 / road 2, in ticks
//   Y_T        : yellow duration (both roads), in ticks
//   AR_T       : all-red clearance duration, in ticks
//   PED_T      : pedestrian walk duration, in ticks
//   TW         : timer width; every duration must be 1..2^TW-1
//
// Ports
//   clk        in   clock
//   reset      in   asynchronous reset, active high
//   tick       in   one-cycle time-base enable
//   ped_req    in   pedestrian button (level or pulse)
//   mode_flash in   night flashing-mode request
//   out1       out  road-1 lamps {R,Y,G}
//   out2       out  road-2 lamps {R,Y,G}
//   ped_walk   out  pedestrian walk lamp
//   ped_pend   out  latched pedestrian request
//   phase      out  current state code
//
// state | meaning
// ------+-----------------------------------------------
// G1    | road 1 green, road 2 red
// Y1    | road 1 yellow, road 2 red
// AR1   | all red after road 1
// G2    | road 2 green, road 1 red
// Y2    | road 2 yellow, road 1 red
// AR2   | all red after road 2 (also the exit of FLASH)
// PED   | all red, pedestrian walk
// FLASH | both roads flash yellow, one toggle per tick
// ---------------------------------------------------------------------------
module traffic_light_ctrl_p #(
    parameter int G1_T  = 15,
    parameter int G2_T  = 15,
    parameter int Y_T   = 5,
    parameter int AR_T  = 1,
    parameter int PED_T = 8,
    parameter int TW    = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       ped_req,
    input  logic       mode_flash,
    output logic [2:0] out1,
    output logic [2:0] out2,
    output logic       ped_walk,
    output logic       ped_pend,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        S_G1    = 3'd0,
        S_Y1    = 3'd1,
        S_AR1   = 3'd2,
        S_G2    = 3'd3,
        S_Y2    = 3'd4,
        S_AR2   = 3'd5,
        S_PED   = 3'd6,
        S_FLASH = 3'd7
    } state_t;

    // Lamp encodings {Red, Yellow, Green}
    localparam logic [2:0] LAMP_R   = 3'b100;
    localparam logic [2:0] LAMP_Y   = 3'b010;
    localparam logic [2:0] LAMP_G   = 3'b001;
    localparam logic [2:0] LAMP_OFF = 3'b000;

    // Timer reload values: a state lasting N ticks starts at N-1 and leaves
    // on the tick that finds the timer at zero.
    localparam logic [TW-1:0] G1_LD  = TW'(G1_T - 1);
    localparam logic [TW-1:0] G2_LD  = TW'(G2_T - 1);
    localparam logic [TW-1:0] Y_LD   = TW'(Y_T - 1);
    localparam logic [TW-1:0] AR_LD  = TW'(AR_T - 1);
    localparam logic [TW-1:0] PED_LD = TW'(PED_T - 1);

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          flash_q, flash_d;
    logic          ped_pend_q, ped_pend_d;
    logic          ped_clr;

    function automatic logic [TW-1:0] load_for(input state_t s);
        logic [TW-1:0] ld;
        ld = '0;
        case (s)
            S_G1:    ld = G1_LD;
            S_Y1:    ld = Y_LD;
            S_AR1:   ld = AR_LD;
            S_G2:    ld = G2_LD;
            S_Y2:    ld = Y_LD;
            S_AR2:   ld = AR_LD;
            S_PED:   ld = PED_LD;
            default: ld = '0;   // FLASH runs on the flash bit, not the timer
        endcase
        return ld;
    endfunction

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_G1;
            timer_q    <= G1_LD;
            flash_q    <= 1'b0;
            ped_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            flash_q    <= flash_d;
            ped_pend_q <= ped_pend_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        flash_d = flash_q;
        ped_clr = 1'b0;

        if (tick) begin
            if (state_q == S_FLASH) begin
                if (!mode_flash) begin
                    // Leave through a full all-red clearance before traffic resumes
                    state_d = S_AR2;
                    timer_d = AR_LD;
                    flash_d = 1'b0;
                end else begin
                    flash_d = ~flash_q;
                end
            end else if (timer_q == '0) begin
                case (state_q)
                    S_G1:  state_d = S_Y1;
                    S_Y1:  state_d = S_AR1;
                    S_AR1: state_d = mode_flash ? S_FLASH : S_G2;
                    S_G2:  state_d = S_Y2;
                    S_Y2:  state_d = S_AR2;
                    // Flash request outranks a pending pedestrian; the
                    // request stays latched and is served after FLASH exits.
                    S_AR2: begin
                        if (mode_flash) begin
                            state_d = S_FLASH;
                        end else if (ped_pend_q) begin
                            state_d = S_PED;
                        end else begin
                            state_d = S_G1;
                        end
                    end
                    S_PED:   state_d = S_G1;
                    default: state_d = S_G1;
                endcase
                timer_d = load_for(state_d);
                flash_d = 1'b0;
                ped_clr = (state_d == S_PED);
            end else begin
                timer_d = timer_q - 1'b1;
            end
        end

        // Clearing on PED entry wins over a press on that same clock; any
        // press seen while in PED re-arms the request for the next cycle.
        ped_pend_d = ped_clr ? 1'b0 : (ped_pend_q | ped_req);
    end

    // ------------------------------------------------------------------
    // Output decode (registered state only)
    // ------------------------------------------------------------------
    always_comb begin
        out1     = LAMP_R;
        out2     = LAMP_R;
        ped_walk = 1'b0;
        case (state_q)
            S_G1: begin
                out1 = LAMP_G;
                out2 = LAMP_R;
            end
            S_Y1: begin
                out1 = LAMP_Y;
                out2 = LAMP_R;
            end
            S_G2: begin
                out1 = LAMP_R;
                out2 = LAMP_G;
            end
            S_Y2: begin
                out1 = LAMP_R;
                out2 = LAMP_Y;
            end
            S_PED: begin
                ped_walk = 1'b1;
            end
            S_FLASH: begin
                out1 = flash_q ? LAMP_OFF : LAMP_Y;
                out2 = flash_q ? LAMP_OFF : LAMP_Y;
            end
            default: begin
                out1 = LAMP_R;
                out2 = LAMP_R;
            end
        endcase
    end

    assign ped_pend = ped_pend_q;
    assign phase    = state_q;

endmodule
